// File: rtl/pixie_pkg.sv
// Shared timing constants and DMA state type for the CDP1861 Pixie video generator.
// Timing is counted in CPU machine cycles (mc) and scan lines.
package pixie_pkg;

    localparam int MC_PER_LINE    = 14;
    localparam int LINES          = 262;
    localparam int FIRST_LINE     = 80;
    localparam int DISP_LINES     = 128;
    localparam int BYTES_PER_LINE = 8;
    localparam int DMA_START_MC   = 2;
    localparam int HSYNC_MCS      = 2;
    localparam int VSYNC_LINES    = 16;

    // The CPU sees INT two lines and EF1 four lines ahead of the window edges
    localparam int INT_FIRST      = FIRST_LINE - 2;
    localparam int EF1_TOP_FIRST  = FIRST_LINE - 4;
    localparam int EF1_BOT_FIRST  = FIRST_LINE + DISP_LINES - 4;
    localparam int LAST_DISP_LINE = FIRST_LINE + DISP_LINES - 1;

    localparam int MC_W   = $clog2(MC_PER_LINE);
    localparam int LINE_W = $clog2(LINES);
    localparam int BYTE_W = $clog2(BYTES_PER_LINE + 1);

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_REQ,
        DMA_DONE
    } dmaState_t;

endpackage

// File: rtl/pixie_shifter.sv
// Byte-wide pixel serialiser: parallel load beats shift, output blanked outside
// the display window.
module pixie_shifter (
    input  logic       CLOCK,
    input  logic       CLEAR_N,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_enable,
    output logic       o_pixel
);

    logic [7:0] r_shift;
    logic       r_pixel;

    always_ff @(posedge CLOCK) begin
        if (!CLEAR_N) begin
            r_shift <= '0;
            r_pixel <= 1'b0;
        end else begin
            r_pixel <= i_enable & r_shift[7];
            if (i_load) begin
                r_shift <= i_data;
            end else begin
                r_shift <= {r_shift[6:0], 1'b0};
            end
        end
    end

    assign o_pixel = r_pixel;

endmodule

// File: rtl/cdp1861_pixie.sv
// CDP1861-style video generator: machine-cycle timebase, DMA-out request FSM,
// CPU interrupt/flag decode and sync generation, feeding a pixel serialiser.
module cdp1861_pixie
    import pixie_pkg::*;
(
    input  logic       CLOCK,
    input  logic       CLEAR_N,
    input  logic       mc_en,
    input  logic       disp_on,
    input  logic       disp_off,
    input  logic       dma_ack,
    input  logic [7:0] dma_data,
    output logic       dma_out_req,
    output logic       INT_N,
    output logic       EF1_N,
    output logic       pixel,
    output logic       de,
    output logic       hsync_n,
    output logic       vsync_n
);

    logic [MC_W-1:0]   r_mcCnt;
    logic [LINE_W-1:0] r_lineCnt;
    logic [BYTE_W-1:0] r_byteCnt;
    logic              r_dispEn;
    logic              r_lineActive;
    dmaState_t         r_state;
    dmaState_t         w_nextState;

    logic r_dmaOutReq;
    logic r_intN;
    logic r_ef1N;
    logic r_hsyncN;
    logic r_vsyncN;

    logic w_mcLast;
    logic w_mcWrap;
    logic w_lineLast;
    logic w_inWindow;
    logic w_intLines;
    logic w_ef1Lines;
    logic w_load;

    assign w_mcLast   = (r_mcCnt == MC_W'(MC_PER_LINE - 1));
    assign w_mcWrap   = mc_en && w_mcLast;
    assign w_lineLast = (r_lineCnt == LINE_W'(LINES - 1));
    assign w_inWindow = (r_lineCnt >= LINE_W'(FIRST_LINE)) &&
                        (r_lineCnt <= LINE_W'(LAST_DISP_LINE));
    assign w_intLines = (r_lineCnt == LINE_W'(INT_FIRST)) ||
                        (r_lineCnt == LINE_W'(INT_FIRST + 1));
    assign w_ef1Lines = ((r_lineCnt >= LINE_W'(EF1_TOP_FIRST)) &&
                         (r_lineCnt <= LINE_W'(FIRST_LINE - 1))) ||
                        ((r_lineCnt >= LINE_W'(EF1_BOT_FIRST)) &&
                         (r_lineCnt <= LINE_W'(LAST_DISP_LINE)));
    assign w_load     = (r_state == DMA_REQ) && dma_ack;

    always_ff @(posedge CLOCK) begin
        if (!CLEAR_N) begin
            r_mcCnt   <= '0;
            r_lineCnt <= '0;
        end else if (mc_en) begin
            if (w_mcLast) begin
                r_mcCnt   <= '0;
                r_lineCnt <= w_lineLast ? '0 : r_lineCnt + 1'b1;
            end else begin
                r_mcCnt <= r_mcCnt + 1'b1;
            end
        end
    end

    // line_active is only re-evaluated during machine cycle 0 so a mid-line
    // display change never produces a partial line.
    always_ff @(posedge CLOCK) begin
        if (!CLEAR_N) begin
            r_dispEn     <= 1'b0;
            r_lineActive <= 1'b0;
        end else begin
            if (disp_off) begin
                r_dispEn <= 1'b0;
            end else if (disp_on) begin
                r_dispEn <= 1'b1;
            end
            if (r_mcCnt == '0) begin
                r_lineActive <= r_dispEn && w_inWindow;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!CLEAR_N) begin
            r_state   <= DMA_IDLE;
            r_byteCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if ((r_state == DMA_IDLE) && (w_nextState == DMA_REQ)) begin
                r_byteCnt <= '0;
            end else if (w_load) begin
                r_byteCnt <= r_byteCnt + 1'b1;
            end
        end
    end

    // The request drops on the edge that accepts the last byte, so the CPU
    // never sees a ninth DMA slot on a full line.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            DMA_IDLE: begin
                if (mc_en && (r_mcCnt == MC_W'(DMA_START_MC)) && r_lineActive && !disp_off) begin
                    w_nextState = DMA_REQ;
                end
            end
            DMA_REQ: begin
                if (disp_off || w_mcWrap) begin
                    w_nextState = DMA_IDLE;
                end else if ((w_load && (r_byteCnt == BYTE_W'(BYTES_PER_LINE - 1))) ||
                             (r_byteCnt == BYTE_W'(BYTES_PER_LINE)) || w_mcLast) begin
                    w_nextState = DMA_DONE;
                end
            end
            DMA_DONE: begin
                if (w_mcWrap) begin
                    w_nextState = DMA_IDLE;
                end
            end
            default: w_nextState = DMA_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!CLEAR_N) begin
            r_dmaOutReq <= 1'b0;
            r_intN      <= 1'b1;
            r_ef1N      <= 1'b1;
            r_hsyncN    <= 1'b1;
            r_vsyncN    <= 1'b1;
        end else begin
            r_dmaOutReq <= (w_nextState == DMA_REQ);
            r_intN      <= !(r_dispEn && w_intLines);
            r_ef1N      <= !w_ef1Lines;
            r_hsyncN    <= (r_mcCnt >= MC_W'(HSYNC_MCS));
            r_vsyncN    <= (r_lineCnt >= LINE_W'(VSYNC_LINES));
        end
    end

    pixie_shifter u_shifter (
        .CLOCK    (CLOCK),
        .CLEAR_N  (CLEAR_N),
        .i_load   (w_load),
        .i_data   (dma_data),
        .i_enable (r_lineActive),
        .o_pixel  (pixel)
    );

    assign dma_out_req = r_dmaOutReq;
    assign INT_N       = r_intN;
    assign EF1_N       = r_ef1N;
    assign de          = r_lineActive;
    assign hsync_n     = r_hsyncN;
    assign vsync_n     = r_vsyncN;

endmodule

// File: tb/tb_cdp1861_pixie.sv
// Self-checking bench for cdp1861_pixie: frame-timing model in lockstep with the
// DUT plus a pixel scoreboard fed by the DMA bytes the bench supplies.
`timescale 1ns/1ps
module tb_cdp1861_pixie;

    logic       CLOCK = 1'b0;
    logic       CLEAR_N;
    logic       mc_en;
    logic       disp_on;
    logic       disp_off;
    logic       dma_ack;
    logic [7:0] dma_data;
    logic       dma_out_req;
    logic       INT_N;
    logic       EF1_N;
    logic       pixel;
    logic       de;
    logic       hsync_n;
    logic       vsync_n;

    int   checks = 0;
    int   passes = 0;
    int   mcM    = 0;
    int   lineM  = 0;
    int   phase  = 0;
    bit   dispEnM;
    bit   lineActM;
    bit   frameCheck;
    bit   ok;
    bit   reqSeen;
    logic expQ[$];
    logic [7:0] dmaBytes [8];

    cdp1861_pixie dut (
        .CLOCK       (CLOCK),
        .CLEAR_N     (CLEAR_N),
        .mc_en       (mc_en),
        .disp_on     (disp_on),
        .disp_off    (disp_off),
        .dma_ack     (dma_ack),
        .dma_data    (dma_data),
        .dma_out_req (dma_out_req),
        .INT_N       (INT_N),
        .EF1_N       (EF1_N),
        .pixel       (pixel),
        .de          (de),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (line %0d mc %0d)", tag, got, exp, lineM, mcM);
        end
    endtask

    // One CLOCK: drive inputs, advance the timing model, then score outputs.
    task automatic applyStimulus(input bit on, input bit off, input bit ack,
                                 input logic [7:0] data, input bit expectLoad);
        bit mcEnNow;
        mcEnNow  = (phase == 0);
        disp_on  = on;
        disp_off = off;
        dma_ack  = ack;
        dma_data = data;
        mc_en    = mcEnNow;
        @(posedge CLOCK);
        if (!CLEAR_N) begin
            mcM = 0; lineM = 0; dispEnM = 0; lineActM = 0;
            expQ.delete();
        end else begin
            if (mcM == 0) lineActM = dispEnM && (lineM >= 80) && (lineM < 208);
            if (off) dispEnM = 0;
            else if (on) dispEnM = 1;
            if (mcEnNow) begin
                if (mcM == 13) begin
                    mcM   = 0;
                    lineM = (lineM == 261) ? 0 : lineM + 1;
                end else begin
                    mcM++;
                end
            end
        end
        phase = (phase + 1) % 8;
        #1;
        disp_on  = 1'b0;
        disp_off = 1'b0;
        dma_ack  = 1'b0;
        dma_data = 8'h00;
        if (expQ.size() > 0) checkOutput("pixel", 32'(pixel), 32'(expQ.pop_front()));
        if (expectLoad) for (int b = 7; b >= 0; b--) expQ.push_back(data[b]);
        if (frameCheck && CLEAR_N && phase == 4) begin
            if (mcM == 7) begin
                checkOutput("vsync_n", 32'(vsync_n), 32'(lineM >= 16));
                checkOutput("EF1_N", 32'(EF1_N),
                            32'(!(((lineM >= 76) && (lineM <= 79)) || ((lineM >= 204) && (lineM <= 207)))));
                checkOutput("INT_N", 32'(INT_N), 32'(!(dispEnM && ((lineM == 78) || (lineM == 79)))));
                checkOutput("de", 32'(de), 32'(lineActM));
            end
            if (lineM == 5) checkOutput("hsync_n", 32'(hsync_n), 32'(mcM >= 2));
        end
    endtask

    task automatic runTo(input int line, input int mc, input int ph);
        int guard;
        guard = 0;
        while (!((lineM == line) && (mcM == mc) && (phase == ph))) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            guard++;
            if (guard > 40000) begin
                checkOutput("runToTimeout", 32'd0, 32'd1);
                return;
            end
        end
    endtask

    task automatic waitReq(output bit found);
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (dma_out_req) begin
                found = 1'b1;
                return;
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        checkOutput("reqTimeout", 32'd0, 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " dma_out_req"}, 32'(dma_out_req), 32'd0);
        checkOutput({tag, " INT_N"},       32'(INT_N),       32'd1);
        checkOutput({tag, " EF1_N"},       32'(EF1_N),       32'd1);
        checkOutput({tag, " pixel"},       32'(pixel),       32'd0);
        checkOutput({tag, " de"},          32'(de),          32'd0);
        checkOutput({tag, " hsync_n"},     32'(hsync_n),     32'd1);
        checkOutput({tag, " vsync_n"},     32'(vsync_n),     32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        dmaBytes   = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h3C, 8'hC3, 8'h7E};
        CLEAR_N    = 1'b0;
        mc_en      = 1'b0;
        disp_on    = 1'b0;
        disp_off   = 1'b0;
        dma_ack    = 1'b0;
        dma_data   = 8'h00;
        frameCheck = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkResetOutputs("por");
        CLEAR_N    = 1'b1;
        frameCheck = 1'b1;

        // Frame 0: display on, then reset in the middle of a REQ on line 100
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        runTo(100, 5, 2);
        checkOutput("req line 100", 32'(dma_out_req), 32'd1);
        CLEAR_N    = 1'b0;
        frameCheck = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkResetOutputs("midRst");
        CLEAR_N    = 1'b1;
        frameCheck = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("post dma_out_req", 32'(dma_out_req), 32'd0);
        checkOutput("post mcCnt", 32'(dut.r_mcCnt), 32'(mcM));
        checkOutput("post lineCnt", 32'(dut.r_lineCnt), 32'd0);

        // Frame 1: display control corner cases
        runTo(0, 1, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        runTo(79, 7, 5);
        checkOutput("INT_N on+off", 32'(INT_N), 32'd1);
        runTo(80, 5, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        reqSeen = 1'b0;
        while (lineM == 80) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            if (dma_out_req) reqSeen = 1'b1;
        end
        checkOutput("no req line 80", 32'(reqSeen), 32'd0);
        runTo(81, 4, 0);
        checkOutput("req line 81", 32'(dma_out_req), 32'd1);
        runTo(82, 0, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        repeat (12) expQ.push_back(1'b0);
        runTo(82, 5, 0);
        checkOutput("req before off", 32'(dma_out_req), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("req after off", 32'(dma_out_req), 32'd0);
        runTo(82, 10, 0);
        checkOutput("req stays low", 32'(dma_out_req), 32'd0);
        runTo(83, 7, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        runTo(0, 0, 1);

        // Frame 2: full DMA line, truncated line, then the rest of the frame
        runTo(80, 0, 1);
        for (int k = 0; k < 8; k++) begin
            waitReq(ok);
            applyStimulus(1'b0, 1'b0, 1'b1, dmaBytes[k], 1'b1);
            if (k == 7) begin
                checkOutput("req drop after 8th", 32'(dma_out_req), 32'd0);
            end else begin
                checkOutput("req held", 32'(dma_out_req), 32'd1);
                repeat (7) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        repeat (8) expQ.push_back(1'b0);

        runTo(81, 12, 1);
        checkOutput("req before trunc ack", 32'(dma_out_req), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h96, 1'b1);
        runTo(81, 13, 3);
        checkOutput("req dropped mc13", 32'(dma_out_req), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        repeat (8) expQ.push_back(1'b0);
        runTo(82, 4, 0);
        checkOutput("req line 82", 32'(dma_out_req), 32'd1);
        runTo(0, 0, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
